keypad_scan_gen: RTL and testbench
==================================

# keypad_scan_gen

Parametrised, debounced matrix-keypad scanner with a key-event queue. It drives one active-low row line at a time and samples active-low column inputs. Scans are filtered over several full frames, and the block publishes both the debounced key bitmap and a press/release event stream through a valid/ready FIFO. It sits between the board keypad pins and the application FSM, and replaces the fixed 4x4, undebounced scanner.

## Interface
- ROWS, 4, number of row drive lines (2..8)
- COLS, 4, number of column sense lines (2..8)
- SCAN_DIV, 1000, clock cycles each row is held low (≥2)
- DEBOUNCE, 4, consecutive identical frames required before commit (≥1)
- FIFO_DEPTH, 4, event queue entries (power of two, ≥2)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- col  in  COLS  column sense, active-low (pulled up off-chip)
- row  out  ROWS  row drive, one-cold active-low
- key  out  ROWS*COLS  debounced state; bit r*COLS+c = key at row[r]/col[c]
- change  out  1  one-cycle pulse when `key` updates
- ev_valid  out  1  event queue non-empty
- ev_code  out  clog2(ROWS*COLS)  key index of head event
- ev_press  out  1  head event: 1 = press, 0 = release
- ev_ready  in  1  consumer accepts head event
- ghost  out  1  one-cycle pulse when a frame is rejected as ghosted (0 when feature out)

## Operation
- Scan order: row[ROWS-1], row[ROWS-2], … row[0], then wrap. One full pass is one frame.
- Dwell counter runs 0..SCAN_DIV-1 per row.
- `col` is sampled into the raw frame on the last dwell cycle only. Each row's slice of the raw frame is fully rewritten, never OR-accumulated.
- At frame end (last dwell cycle of row[0]):
  - raw == previous raw: stable counter increments, saturating at DEBOUNCE.
  - raw != previous raw: stable counter is set to 1.
- Commit condition: stable counter == DEBOUNCE, raw != `key`, and the diff register is zero.
  - On commit: diff <= raw ^ key, key <= raw, `change` pulses.
  - If diff is non-zero, commit is deferred to a later frame end. No frame data is lost because raw is still stable.
- Event generator: each cycle where diff != 0 and the FIFO is not full:
  - Take the lowest set bit i.
  - Push {code=i, press=key[i]}.
  - Clear diff[i].
  - A full FIFO stalls the generator; events are never dropped.
- FIFO: `ev_valid` = !empty; the head is shown on `ev_code`/`ev_press`; pop on ev_valid & ev_ready. Push and pop in the same cycle when full is allowed: the pop frees the slot.
- States: SCAN (dwell counting) is always active; the commit and event logic run alongside it.

## Timing
- Reset: row = one-cold with row[ROWS-1] low; key = 0; change = 0; ghost = 0; ev_valid = 0; ev_code = 0; ev_press = 0. Dwell, stable counter, raw, diff and FIFO are cleared.
- Reset mid-scan clears everything immediately. Queued events are discarded.
- `row` changes on the clock edge after the last dwell cycle.
- Frame period: ROWS*SCAN_DIV cycles.
- Press latency: stable input for DEBOUNCE frames → `key`/`change` updated 1 cycle after that frame's end edge. The first event appears on `ev_valid` 1 cycle after `change`.
- N simultaneous changes produce N events on N consecutive cycles, ascending index, when the FIFO has room.
- Data from `ev_code`/`ev_press` is registered from FIFO storage, with no combinational path from `ev_ready`.

## Configuration
- KEYPAD_SCAN_GHOST_MASK_EN defined:
  - At frame end, a raw frame in which any two rows share two or more pressed columns is rejected.
  - On rejection: the stable counter resets to 0, previous raw is still updated, `ghost` pulses for 1 cycle, and no commit occurs.
- Undefined: no ghost check; `ghost` is tied to 0.

## Test plan
(ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE=2, FIFO_DEPTH=4)
- Reset release, idle cols=4'hF → row cycles 0111, 1011, 1101, 1110 every 4 clocks; key=0; no `change`, no events.
- Hold col[1] low only while row=1011 for 3 frames → key=16'h0200 after the end of frame 2, `change` pulse, one event {code=9, press=1}. Release → later {9, 0} and key=0.
- Bounce: toggle the key every frame for 6 frames → no commit, no events. Then hold for 2 frames → single commit.
- Press keys 0, 5, 10, 15, 12 together with ev_ready=0 → 4 events queued (0, 5, 10, 12). The fifth (15) stalls until one pop, then enters; order is ascending.
- Assert rst while 2 events are queued → ev_valid=0 next cycle, key=0, row=0111.
- With KEYPAD_SCAN_GHOST_MASK_EN, press keys 0, 1, 4 → frame shows 0, 1, 4, 5: `ghost` pulses every frame and key stays unchanged. Without the macro → key=16'h0033.

Source files
------------

// File: rtl/keypad_scan_gen.sv
// keypad_scan_gen
//   Debounced matrix-keypad scanner with a press/release event queue.
//   One active-low row is driven at a time, scanning from row[ROWS-1] down
//   to row[0]. The active-low columns are sampled on the last dwell cycle
//   of each row. A frame is committed to `key` once it has been identical
//   for DEBOUNCE consecutive frames. Each changed bit then becomes one
//   event in a valid/ready FIFO, lowest index first.
//
//   Optional feature: define KEYPAD_SCAN_GHOST_MASK_EN to reject frames in
//   which two rows share two or more pressed columns. Such a frame pulses
//   `ghost` and resets the stability count.
//
// Ports
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   col      : column sense, active-low
//   row      : row drive, one-cold active-low
//   key      : debounced key bitmap, bit r*COLS+c = row r / column c
//   change   : one-cycle pulse when `key` updates
//   ev_valid : event queue non-empty
//   ev_code  : key index of head event
//   ev_press : head event is a press (1) or a release (0)
//   ev_ready : consumer accepts head event
//   ghost    : one-cycle pulse on a rejected (ghosted) frame
module keypad_scan_gen #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COLS-1:0]              col,
  output logic [ROWS-1:0]              row,
  output logic [ROWS*COLS-1:0]         key,
  output logic                         change,
  output logic                         ev_valid,
  output logic [$clog2(ROWS*COLS)-1:0] ev_code,
  output logic                         ev_press,
  input  logic                         ev_ready,
  output logic                         ghost
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned CW = $clog2(N);
  localparam int unsigned RW = $clog2(ROWS);
  localparam int unsigned DW = $clog2(SCAN_DIV);
  localparam int unsigned SW = $clog2(DEBOUNCE + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef logic [CW:0] entry_t;  // {code, press}

  logic [RW-1:0] row_idx_q, row_idx_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [N-1:0]  raw_q, raw_d, prev_q, prev_d, key_q, key_d, diff_q, diff_d;
  logic [SW-1:0] stable_q, stable_d;
  logic          change_q, change_d;
  logic          last_dwell, frame_end, frame_ghost;
  logic [CW-1:0] lo_idx;
  logic          push, pop, full;

  entry_t        mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;

`ifdef KEYPAD_SCAN_GHOST_MASK_EN
  logic ghost_q;

  // Two rows sharing two pressed columns form a rectangle whose fourth
  // corner may be a phantom key.
  function automatic logic is_ghost(input logic [N-1:0] f);
    logic [COLS-1:0] shared;
    is_ghost = 1'b0;
    for (int unsigned a = 0; a < ROWS; a++) begin
      for (int unsigned b = a + 1; b < ROWS; b++) begin
        shared = f[a*COLS +: COLS] & f[b*COLS +: COLS];
        if ((shared & (shared - COLS'(1))) != '0) is_ghost = 1'b1;
      end
    end
  endfunction
`endif

  assign ev_valid = (cnt_q != '0);
  assign full     = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign pop      = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push     = (diff_q != '0) && (!full || pop);

  assign {ev_code, ev_press} = mem_q[rd_q];
  assign key    = key_q;
  assign change = change_q;

  always_comb begin
    row = '1;
    row[row_idx_q] = 1'b0;
  end

  always_comb begin
    row_idx_d   = row_idx_q;
    dwell_d     = dwell_q;
    raw_d       = raw_q;
    prev_d      = prev_q;
    key_d       = key_q;
    diff_d      = diff_q;
    stable_d    = stable_q;
    change_d    = 1'b0;
    frame_ghost = 1'b0;
    lo_idx      = '0;

    last_dwell = (dwell_q == DW'(SCAN_DIV - 1));
    frame_end  = last_dwell && (row_idx_q == '0);

    if (last_dwell) begin
      dwell_d   = '0;
      row_idx_d = (row_idx_q == '0) ? RW'(ROWS - 1) : row_idx_q - RW'(1);
      for (int unsigned r = 0; r < ROWS; r++) begin
        if (row_idx_q == RW'(r)) raw_d[r*COLS +: COLS] = ~col;
      end
    end else begin
      dwell_d = dwell_q + DW'(1);
    end

`ifdef KEYPAD_SCAN_GHOST_MASK_EN
    frame_ghost = is_ghost(raw_d);
`endif

    // raw_d already holds row[0]'s sample, so the full frame is judged here.
    if (frame_end) begin
      prev_d = raw_d;
      if (frame_ghost)
        stable_d = '0;
      else if (raw_d == prev_q)
        stable_d = (stable_q == SW'(DEBOUNCE)) ? stable_q : stable_q + SW'(1);
      else
        stable_d = SW'(1);

      // Pending events defer the commit; raw stays stable, so it retries.
      if (!frame_ghost && stable_d == SW'(DEBOUNCE) && raw_d != key_q &&
          diff_q == '0) begin
        diff_d   = raw_d ^ key_q;
        key_d    = raw_d;
        change_d = 1'b1;
      end
    end

    for (int unsigned i = N; i > 0; i--) begin
      if (diff_q[i-1]) lo_idx = CW'(i - 1);
    end
    if (push) diff_d[lo_idx] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_idx_q <= RW'(ROWS - 1);
      dwell_q   <= '0;
      raw_q     <= '0;
      prev_q    <= '0;
      key_q     <= '0;
      diff_q    <= '0;
      stable_q  <= '0;
      change_q  <= 1'b0;
    end else begin
      row_idx_q <= row_idx_d;
      dwell_q   <= dwell_d;
      raw_q     <= raw_d;
      prev_q    <= prev_d;
      key_q     <= key_d;
      diff_q    <= diff_d;
      stable_q  <= stable_d;
      change_q  <= change_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {lo_idx, key_q[lo_idx]};
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef KEYPAD_SCAN_GHOST_MASK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghost_q <= 1'b0;
    else     ghost_q <= frame_end && frame_ghost;
  end
  assign ghost = ghost_q;
`else
  assign ghost = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scan_gen.sv
module tb_keypad_scan_gen;
  localparam int unsigned ROWS       = 4;
  localparam int unsigned COLS       = 4;
  localparam int unsigned SCAN_DIV   = 4;
  localparam int unsigned DEBOUNCE   = 2;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned N          = ROWS * COLS;
  localparam int unsigned FRAME      = ROWS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [15:0] key;
  logic        change, ev_valid, ev_press, ghost, ev_ready;
  logic [3:0]  ev_code;

  logic [15:0] pressed = '0;
  int unsigned drv_row = ROWS - 1;
  logic        ready_drv = 1'b0;

  assign col      = ~pressed[drv_row*COLS +: COLS];
  assign ev_ready = ready_drv;

  keypad_scan_gen #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .col(col), .row(row), .key(key),
    .change(change), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_press(ev_press), .ev_ready(ev_ready), .ghost(ghost)
  );

  always #5 clk = ~clk;

  // Reference model: cycle count since reset, last frames, event queues.
  int unsigned m_t = 0;
  int unsigned m_row = ROWS - 1;
  logic [15:0] m_key = '0;
  logic [15:0] m_frame = '0;
  bit          m_change = 0;
  bit          m_ghost = 0;
  int unsigned fifo[$];
  int unsigned pend[$];
  logic [15:0] hist[$];

  function automatic bit frame_ghosted(input logic [15:0] f);
    for (int unsigned c1 = 0; c1 < COLS; c1++) begin
      for (int unsigned c2 = c1 + 1; c2 < COLS; c2++) begin
        int unsigned n = 0;
        for (int unsigned r = 0; r < ROWS; r++)
          if (f[r*COLS+c1] && f[r*COLS+c2]) n++;
        if (n >= 2) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    bit do_pop, was_empty, is_g;
    if (rst) begin
      m_t = 0; m_row = ROWS - 1; m_key = '0; m_frame = '0;
      m_change = 0; m_ghost = 0;
      fifo.delete(); pend.delete(); hist.delete();
    end else begin
      do_pop    = (fifo.size() != 0) && ready_drv;
      was_empty = (pend.size() == 0);
      m_change  = 0;
      m_ghost   = 0;
      if (do_pop) void'(fifo.pop_front());
      if (pend.size() != 0 && fifo.size() < FIFO_DEPTH) fifo.push_back(pend.pop_front());
      if (m_t % SCAN_DIV == SCAN_DIV - 1) begin
        for (int unsigned c = 0; c < COLS; c++) m_frame[m_row*COLS+c] = !col[c];
        if (m_row == 0) begin
          is_g = 0;
`ifdef KEYPAD_SCAN_GHOST_MASK_EN
          is_g = frame_ghosted(m_frame);
`endif
          if (is_g) begin
            hist.delete();
            m_ghost = 1;
          end else begin
            if (hist.size() != 0 && hist[hist.size()-1] != m_frame) hist.delete();
            hist.push_back(m_frame);
            if (hist.size() > DEBOUNCE) void'(hist.pop_front());
            if (hist.size() == DEBOUNCE && m_frame != m_key && was_empty) begin
              for (int unsigned i = 0; i < N; i++)
                if (m_frame[i] != m_key[i]) pend.push_back(i*2 + 32'(m_frame[i]));
              m_key    = m_frame;
              m_change = 1;
            end
          end
        end
      end
      m_t++;
      m_row = ROWS - 1 - ((m_t / SCAN_DIV) % ROWS);
    end
  end

  int total = 0;
  int bad = 0;
  int chg_cnt = 0;
  int ghost_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [3:0] er;
    @(negedge clk);
    er = '1;
    er[m_row] = 1'b0;
    check("row", 32'(row), 32'(er));
    check("key", 32'(key), 32'(m_key));
    check("change", 32'(change), 32'(m_change));
    check("ghost", 32'(ghost), 32'(m_ghost));
    check("ev_valid", 32'(ev_valid), 32'(fifo.size() != 0));
    if (fifo.size() != 0) check("ev_head", 32'({ev_code, ev_press}), fifo[0]);
    if (change === 1'b1) chg_cnt++;
    if (ghost === 1'b1) ghost_cnt++;
    drv_row = m_row;
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_change(input string name, input int max, output int n);
    bit seen = 0;
    n = 0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      n++;
      if (change === 1'b1) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic align();
    for (int i = 0; i < int'(FRAME) && (m_t % FRAME) != 0; i++) tick();
  endtask

  initial begin
    int n;
    int exp_codes[5];
    int mode;
    exp_codes = '{0, 5, 10, 12, 15};

    run(3);
    check("rst_row", 32'(row), 32'h7);
    check("rst_key", 32'(key), 32'h0);
    check("rst_valid", 32'(ev_valid), 32'h0);
    check("rst_code", 32'({ev_code, ev_press}), 32'h0);
    check("rst_change", 32'(change), 32'h0);
    rst = 1'b0;

    // Idle scan.
    for (int k = 1; k <= 16; k++) begin
      tick();
      case (k)
        3:  check("idle_row3", 32'(row), 32'h7);
        4:  check("idle_row4", 32'(row), 32'hB);
        8:  check("idle_row8", 32'(row), 32'hD);
        12: check("idle_row12", 32'(row), 32'hE);
        16: check("idle_row16", 32'(row), 32'h7);
        default: ;
      endcase
    end
    check("idle_nochange", 32'(chg_cnt), 32'd0);

    // Single key 9, press then release.
    align();
    pressed = 16'h0200;
    wait_change("press9_commit", 4*FRAME, n);
    check("press9_latency", 32'(n), 32'd32);
    check("press9_key", 32'(key), 32'h0200);
    tick();
    check("press9_valid", 32'(ev_valid), 32'd1);
    check("press9_ev", 32'({ev_code, ev_press}), 32'h13);
    ready_drv = 1'b1; tick(); ready_drv = 1'b0;
    check("press9_single", 32'(ev_valid), 32'd0);
    pressed = '0;
    wait_change("rel9_commit", 4*FRAME, n);
    check("rel9_key", 32'(key), 32'h0);
    tick();
    check("rel9_ev", 32'({ev_code, ev_press}), 32'h12);
    ready_drv = 1'b1; tick(); ready_drv = 1'b0;

    // Bounce for 6 frames, then hold.
    align();
    chg_cnt = 0;
    for (int f = 0; f < 6; f++) begin
      pressed = (f % 2 == 0) ? 16'h0200 : 16'h0000;
      run(FRAME);
    end
    check("bounce_nochange", 32'(chg_cnt), 32'd0);
    check("bounce_noevent", 32'(ev_valid), 32'd0);
    pressed = 16'h0200;
    run(2*FRAME + 2);
    check("bounce_commit_once", 32'(chg_cnt), 32'd1);
    check("bounce_key", 32'(key), 32'h0200);
    ready_drv = 1'b1; pressed = '0;
    run(4*FRAME);
    ready_drv = 1'b0;
    check("bounce_rel_key", 32'(key), 32'h0);

    // Five keys at once with the consumer stalled.
    align();
    pressed = 16'h9421;
    wait_change("multi_commit", 4*FRAME, n);
    run(8);
    for (int j = 0; j < 5; j++) begin
      check("multi_valid", 32'(ev_valid), 32'd1);
      check("multi_order", 32'({ev_code, ev_press}), 32'(exp_codes[j]*2 + 1));
      ready_drv = 1'b1; tick(); ready_drv = 1'b0;
    end
    check("multi_drained", 32'(ev_valid), 32'd0);

    // Reset with events queued.
    pressed = '0;
    wait_change("multi_release", 4*FRAME, n);
    run(3);
    check("prerst_valid", 32'(ev_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("midrst_valid", 32'(ev_valid), 32'd0);
    check("midrst_key", 32'(key), 32'h0);
    check("midrst_row", 32'(row), 32'h7);
    tick();
    rst = 1'b0;

    // Rectangle of keys 0,1,4,5.
    pressed = 16'h0033;
`ifdef KEYPAD_SCAN_GHOST_MASK_EN
    ghost_cnt = 0;
    run(5*FRAME);
    check("ghost_pulses", 32'(ghost_cnt >= 4), 32'd1);
    check("ghost_key", 32'(key), 32'h0);
`else
    wait_change("noghost_commit", 4*FRAME, n);
    check("noghost_key", 32'(key), 32'h0033);
`endif
    pressed = '0;
    ready_drv = 1'b1;
    run(4*FRAME);

    // Random keys and consumer pacing.
    for (int blk = 0; blk < 25; blk++) begin
      mode = $urandom_range(0, 2);
      if (blk == 12) begin
        rst = 1'b1; run(2); rst = 1'b0;
      end
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 47) == 0) pressed = 16'($urandom() & $urandom() & $urandom());
        case (mode)
          0: ready_drv = ($urandom_range(0, 9) != 0);
          1: ready_drv = ($urandom_range(0, 2) == 0);
          default: ready_drv = 1'b0;
        endcase
        tick();
      end
    end

    pressed = '0;
    ready_drv = 1'b1;
    run(8*FRAME);
    check("final_empty", 32'(ev_valid), 32'd0);
    check("final_key", 32'(key), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
